// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: redirect select encodings and default vectors.
package cpu_pkg;

    localparam logic [2:0] PC_SEQ = 3'b000;
    localparam logic [2:0] PC_J   = 3'b001;
    localparam logic [2:0] PC_JR  = 3'b010;
    localparam logic [2:0] PC_BR  = 3'b011;
    localparam logic [2:0] PC_JAL = 3'b100;
    localparam logic [2:0] PC_RET = 3'b101;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module return_addr_stack #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic              empty,
    output logic              overflow
);

    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] stack_mem [DEPTH];
    logic [PW-1:0]     ptr;    // next write slot; top entry sits one below
    logic [PW:0]       count;
    logic              full;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign top_data = stack_mem[ptr - PW'(1)];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (full) overflow <= 1'b1;
            else      count    <= count + (PW+1)'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr - PW'(1);
            count <= count - (PW+1)'(1);
        end
    end

    // Contents are don't-care after reset; count alone marks them invalid.
    always_ff @(posedge clk) begin
        if (push) stack_mem[ptr] <= push_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: redirect muxing, exception entry/return, and RAS-predicted returns.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int              ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEF_EXC_VECTOR),
    parameter int              RAS_DEPTH    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [2:0]        pc_control,
    input  logic [25:0]       jmp_addr,
    input  logic [15:0]       branch_offset,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic              exc_req,
    input  logic              eret,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_addr,
    output logic [ADDR_W-1:0] epc,
    output logic              ras_empty,
    output logic              ras_overflow,
    output logic              align_err
);

    logic [ADDR_W-1:0] seq_pc, j_target, br_target, reg_target, ras_top;
    logic [ADDR_W-1:0] pc_next, epc_next;
    logic              align_next, ras_push, ras_pop;

    assign seq_pc     = pc + ADDR_W'(4);
    assign link_addr  = seq_pc;
    assign j_target   = {seq_pc[ADDR_W-1:28], jmp_addr, 2'b00};
    assign br_target  = seq_pc + {{(ADDR_W-18){branch_offset[15]}}, branch_offset, 2'b00};
    assign reg_target = {reg_addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        pc_next    = pc;
        epc_next   = epc;
        align_next = 1'b0;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        if (exc_req) begin
            epc_next = pc;
            pc_next  = EXC_VECTOR;
        end else if (eret) begin
            pc_next = epc;
        end else if (!stall) begin
            unique case (pc_control)
                PC_J:  pc_next = j_target;
                PC_JR: begin
                    pc_next    = reg_target;
                    align_next = |reg_addr[1:0];
                end
                PC_BR:  pc_next = branch_taken ? br_target : seq_pc;
                PC_JAL: begin
                    pc_next  = j_target;
                    ras_push = 1'b1;
                end
                PC_RET: begin
                    // Empty stack: no prediction available, fall back to the register.
                    if (!ras_empty) begin
                        pc_next = ras_top;
                        ras_pop = 1'b1;
                    end else begin
                        pc_next    = reg_target;
                        align_next = |reg_addr[1:0];
                    end
                end
                default: pc_next = seq_pc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_VECTOR;
            epc       <= '0;
            align_err <= 1'b0;
        end else begin
            pc        <= pc_next;
            epc       <= epc_next;
            align_err <= align_next;
        end
    end

    return_addr_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .overflow  (ras_overflow)
    );

endmodule
